// File: rtl/pipe_hazard_ctrl.sv
// Hazard/flush controller for a 5-stage (F,D,X,M,W) pipeline: keeps a per-stage
// scoreboard, resolves RAW/load-use hazards, redirects and memory-busy freezes.
module pipe_hazard_ctrl #(
    parameter int RA_W      = 5,
    parameter bit BYPASS_EN = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             f_valid,
    input  logic [RA_W-1:0]  d_rs1,
    input  logic [RA_W-1:0]  d_rs2,
    input  logic             d_rs1_use,
    input  logic             d_rs2_use,
    input  logic [RA_W-1:0]  d_rd,
    input  logic             d_wen,
    input  logic             d_load,
    input  logic             x_redirect,
    input  logic             m_mem_busy,
    output logic             stall_f,
    output logic             stall_d,
    output logic             kill_f,
    output logic             redirect,
    output logic             valid_x,
    output logic             valid_m,
    output logic             valid_w,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic            v;
        logic [RA_W-1:0] rd;
        logic            wen;
        logic            load;
    } stage_t;

    logic              vd_q, vd_d;
    stage_t            x_q, x_d, m_q, m_d, w_q, w_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic freeze, redir, hazard, stall;
    logic hx1, hx2, hm1, hm2, hw1, hw2;

    // x0 is hard-wired zero, so it can never be a producer worth waiting for.
    function automatic logic hit(stage_t s, logic [RA_W-1:0] rs, logic use_rs);
        return s.v & s.wen & (s.rd != '0) & (s.rd == rs) & use_rs;
    endfunction

    function automatic logic [1:0] fwd_sel(logic hx, logic hm, logic hw, logic x_load);
        logic [1:0] sel;
        sel = 2'd0;
        if (BYPASS_EN) begin
            if (hx & ~x_load) sel = 2'd1;
            else if (hm)      sel = 2'd2;
            else if (hw)      sel = 2'd3;
        end
        return sel;
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        hx1 = hit(x_q, d_rs1, d_rs1_use);
        hx2 = hit(x_q, d_rs2, d_rs2_use);
        hm1 = hit(m_q, d_rs1, d_rs1_use);
        hm2 = hit(m_q, d_rs2, d_rs2_use);
        hw1 = hit(w_q, d_rs1, d_rs1_use);
        hw2 = hit(w_q, d_rs2, d_rs2_use);

        freeze = m_q.v & m_mem_busy;
        redir  = x_q.v & x_redirect & ~freeze;
        hazard = vd_q & (((hx1 | hx2) & x_q.load)
                 | (~BYPASS_EN & (hx1 | hx2 | hm1 | hm2 | hw1 | hw2)));
        stall  = ~freeze & ~redir & hazard;

        stall_f  = freeze | stall;
        stall_d  = freeze | stall;
        kill_f   = redir;
        redirect = redir;
        fwd_a    = fwd_sel(hx1, hm1, hw1, x_q.load);
        fwd_b    = fwd_sel(hx2, hm2, hw2, x_q.load);

        vd_d = vd_q;
        x_d  = x_q;
        m_d  = m_q;
        w_d  = w_q;
        if (freeze) begin
            w_d = '0;
        end else if (redir) begin
            vd_d = 1'b0;
            x_d  = '0;
            m_d  = x_q;
            w_d  = m_q;
        end else if (stall) begin
            x_d = '0;
            m_d = x_q;
            w_d = m_q;
        end else begin
            vd_d = f_valid;
            x_d  = '{v: vd_q, rd: d_rd, wen: d_wen, load: d_load};
            m_d  = x_q;
            w_d  = m_q;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall_d && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
        flush_cnt_d = flush_cnt_q;
        if (redir && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vd_q        <= 1'b0;
            x_q         <= '0;
            m_q         <= '0;
            w_q         <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            vd_q        <= vd_d;
            x_q         <= x_d;
            m_q         <= m_d;
            w_q         <= w_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign valid_x   = x_q.v;
    assign valid_m   = m_q.v;
    assign valid_w   = w_q.v;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
